oled_pixel_streamer: RTL and testbench
======================================

# oled_pixel_streamer

Downstream stage of the pixel generators (border, overlay, sprite blocks). It walks the 96x64 OLED raster by driving `pixel_index` and captures each pixel's RGB565 `pixel_data`. It then serialises a per-frame address preamble followed by 6144 pixels over 4-wire SPI (mode 3) to the SSD1331 panel. Panel power-up and initialisation are owned by a separate block; this block starts streaming only once `enable` is high.

## Interface
Parameters:
- `WIDTH`, 96, pixels per row
- `HEIGHT`, 64, rows per frame
- `SCLK_DIV`, 4, clk25 cycles per SPI bit (even, ≥4)

Ports:
- `clk25`  in  1  25 MHz system clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `enable`  in  1  stream frames continuously while high
- `pixel_data`  in  16  RGB565 from upstream generator, valid 2 cycles after `pixel_index` changes
- `pixel_index`  out  13  raster index 0..6143 (row*96+col)
- `cs_n`  out  1  SPI chip select, active-low
- `sclk`  out  1  SPI clock, idles high
- `mosi`  out  1  SPI data, MSB first
- `dc`  out  1  0 = command byte, 1 = data byte
- `frame_begin`  out  1  one-cycle pulse as the first pixel's fetch starts
- `busy`  out  1  high from leaving IDLE until return to IDLE

## Operation
- Reset values: `cs_n`=1, `sclk`=1, `mosi`=0, `dc`=0, `pixel_index`=0, `frame_begin`=0, `busy`=0. The state machine returns to IDLE.
- FSM states: IDLE, GAP, CMD, FETCH, SHIFT_HI, SHIFT_LO.
- IDLE: when `enable`=1, go to GAP.
- GAP: `cs_n`=1 for 4 cycles, then go to CMD.
- CMD: `cs_n`=0, `dc`=0. Sends 6 bytes: 0x15, 0x00, WIDTH-1, 0x75, 0x00, HEIGHT-1. Then `pixel_index`←0 and go to FETCH.
- FETCH: 3 cycles with `pixel_index` stable. `pixel_data` is captured on the 3rd cycle, then go to SHIFT_HI.
- SHIFT_HI / SHIFT_LO: `dc`=1. Send captured bits [15:8], then [7:0].
- After SHIFT_LO:
  - if `pixel_index` < 6143: increment and go to FETCH;
  - else if `enable`=1: go to GAP (next frame);
  - else: go to IDLE.
- Dropping `enable` mid-frame has no effect until the frame completes. Frames are never truncated.
- `frame_begin` pulses on the first FETCH cycle of pixel 0.
- `cs_n` stays low continuously from the first CMD bit through the last pixel bit.
- `pixel_data` is sampled only in FETCH. Changes at other times are ignored.

## Timing
- Bit cell is SCLK_DIV=4 cycles:
  - phase 0: `sclk`=0, `mosi` updated;
  - phase 1: `sclk`=0;
  - phases 2–3: `sclk`=1. The panel samples on the 0→1 edge.
- SPI rate is 6.25 MHz.
- Byte = 32 cycles, with no gap between consecutive bytes.
- `dc` changes only at phase 0 of a byte's first bit.
- Pixel period = 3 + 64 = 67 cycles.
- Frame period, enable held high = 4 + 192 + 6144×67 = 411 844 cycles.
- Upstream latency contract: the generator must have `pixel_data` valid by the 3rd FETCH cycle. This means ≤2 registered stages after `pixel_index`.
- `pixel_index` wraps 6143→0 only via GAP/CMD. It never exceeds 6143.
- `reset` asserted mid-byte takes effect the next edge: all outputs go to their reset values and the partial byte is abandoned. With `enable` high, the first bit of the next CMD starts 5 cycles after `reset` falls (1 IDLE + 4 GAP).

## Structure
- Shared package `oled_pkg`:
  - constants OLED_WIDTH=96, OLED_HEIGHT=64, OLED_PIXELS=6144;
  - SSD1331 opcodes CMD_SET_COL=0x15, CMD_SET_ROW=0x75;
  - state enum type.
- Sub-module `spi_byte_tx`:
  - inputs: load pulse, 8-bit byte, `dc`;
  - outputs: `sclk`, `mosi`, `dc` and a one-cycle `done` on the last cycle of bit 0;
  - handles the phase counter and bit counter.
- Top FSM sequences the command ROM (6 entries), pixel counter and fetch timer.

## Test plan
- Reset, then `enable`=1. Expect:
  - `cs_n` falls on cycle 5;
  - SPI monitor decodes 6 command bytes 15 00 5F 75 00 3F with `dc`=0;
  - the first data byte has `dc`=1.
- Upstream model returns `pixel_data`=16'hF800 at index 0 and 16'h0000 elsewhere, with a 1-cycle registered latency. Expect:
  - data bytes F8 00, then 00 00 ×6143;
  - exactly 12288 data bytes per frame.
- Hold `enable`=1 for 2 frames. Expect:
  - `frame_begin` pulses exactly 411 844 cycles apart;
  - `cs_n` is high for exactly 4 cycles between frames;
  - `pixel_index` goes 6143 → 0.
- Drop `enable` at pixel 3000. Expect the frame to complete through pixel 6143, then IDLE with `busy`=0, `cs_n`=1, and no further SPI activity.
- Assert `reset` during the 5th bit of a pixel byte. Expect:
  - next cycle: `cs_n`=1, `sclk`=1, `pixel_index`=0;
  - after release, a clean frame restarts from the CMD preamble.
- Check every `sclk` rising edge. Expect `mosi` and `dc` stable for ≥2 cycles before and 1 cycle after the edge, and the measured `sclk` period is 4 cycles.

Source files
------------

// File: rtl/oled_pkg.sv
// Shared SSD1331 constants, FSM state type and the address-window command ROM.
// Consumed by the pixel streamer and its SPI serialiser; no backpressure.
package oled_pkg;

  localparam int OLED_WIDTH  = 96;
  localparam int OLED_HEIGHT = 64;
  localparam int OLED_PIXELS = OLED_WIDTH * OLED_HEIGHT;

  localparam logic [7:0] CMD_SET_COL = 8'h15;
  localparam logic [7:0] CMD_SET_ROW = 8'h75;
  localparam int         CMD_BYTES   = 6;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GAP      = 3'd1,
    ST_CMD      = 3'd2,
    ST_FETCH    = 3'd3,
    ST_SHIFT_HI = 3'd4,
    ST_SHIFT_LO = 3'd5
  } state_e;

  // Full-screen column/row window preamble sent at the start of every frame.
  function automatic logic [7:0] cmd_rom(input logic [2:0] idx, input int width, input int height);
    case (idx)
      3'd0:    return CMD_SET_COL;
      3'd2:    return 8'(width - 1);
      3'd3:    return CMD_SET_ROW;
      3'd5:    return 8'(height - 1);
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/spi_byte_tx.sv
// SPI mode-3 byte serialiser: first bit cell starts the cycle after load, 8*SCLK_DIV cycles per byte.
// No backpressure; the caller reloads on done to stream bytes back to back.
module spi_byte_tx #(
  parameter int SCLK_DIV = 4
) (
  input  logic       clk25,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] byte_dat,
  input  logic       dc_in,
  output logic       sclk,
  output logic       mosi,
  output logic       dc,
  output logic       done
);

  localparam int             PW      = $clog2(SCLK_DIV);
  localparam logic [PW-1:0] PH_LAST = PW'(SCLK_DIV - 1);
  localparam logic [PW-1:0] PH_RISE = PW'(SCLK_DIV / 2);

  logic          active;
  logic [PW-1:0] phase;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;

  always_ff @(posedge clk25) begin
    if (reset) begin
      active  <= 1'b0;
      phase   <= '0;
      bit_cnt <= 3'd0;
      shreg   <= 8'h00;
      dc      <= 1'b0;
    end else if (load) begin
      active  <= 1'b1;
      phase   <= '0;
      bit_cnt <= 3'd7;
      shreg   <= byte_dat;
      dc      <= dc_in;
    end else if (active) begin
      if (phase == PH_LAST) begin
        phase <= '0;
        if (bit_cnt == 3'd0) begin
          active <= 1'b0;
        end else begin
          bit_cnt <= bit_cnt - 3'd1;
          shreg   <= {shreg[6:0], 1'b0};
        end
      end else begin
        phase <= phase + 1'b1;
      end
    end
  end

  // mosi only moves on phase 0, so it is settled two cycles ahead of the rising sclk.
  assign sclk = !active || (phase >= PH_RISE);
  assign mosi = shreg[7];
  assign done = active && (phase == PH_LAST) && (bit_cnt == 3'd0);

endmodule

// File: rtl/oled_pixel_streamer.sv
// Walks the raster, fetches each RGB565 pixel (3-cycle fetch) and streams preamble + pixels to the SSD1331.
// Pixel period 3 + 16*SCLK_DIV cycles; no backpressure, frames always run to completion.
module oled_pixel_streamer
  import oled_pkg::*;
#(
  parameter int WIDTH    = OLED_WIDTH,
  parameter int HEIGHT   = OLED_HEIGHT,
  parameter int SCLK_DIV = 4
) (
  input  logic        clk25,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] pixel_data,
  output logic [12:0] pixel_index,
  output logic        cs_n,
  output logic        sclk,
  output logic        mosi,
  output logic        dc,
  output logic        frame_begin,
  output logic        busy
);

  localparam int          PIXELS   = WIDTH * HEIGHT;
  localparam logic [12:0] LAST_IDX = 13'(PIXELS - 1);
  localparam logic [2:0]  LAST_CMD = 3'(CMD_BYTES - 1);

  state_e     state;
  logic [1:0] gap_cnt;
  logic [1:0] fetch_cnt;
  logic [2:0] cmd_idx;
  logic [7:0] pix_lo;
  logic       tx_load;
  logic       tx_done;
  logic       tx_dc;
  logic [7:0] tx_byte;

  // Loads coincide with the previous byte's done so bytes abut with no idle bit cell.
  always_comb begin
    tx_load = 1'b0;
    tx_byte = 8'h00;
    tx_dc   = 1'b0;
    case (state)
      ST_GAP: if (gap_cnt == 2'd3) begin
        tx_load = 1'b1;
        tx_byte = cmd_rom(3'd0, WIDTH, HEIGHT);
      end
      ST_CMD: if (tx_done && cmd_idx != LAST_CMD) begin
        tx_load = 1'b1;
        tx_byte = cmd_rom(cmd_idx + 3'd1, WIDTH, HEIGHT);
      end
      ST_FETCH: if (fetch_cnt == 2'd2) begin
        tx_load = 1'b1;
        tx_byte = pixel_data[15:8];
        tx_dc   = 1'b1;
      end
      ST_SHIFT_HI: if (tx_done) begin
        tx_load = 1'b1;
        tx_byte = pix_lo;
        tx_dc   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk25) begin
    if (reset) begin
      state       <= ST_IDLE;
      gap_cnt     <= 2'd0;
      fetch_cnt   <= 2'd0;
      cmd_idx     <= 3'd0;
      pix_lo      <= 8'h00;
      pixel_index <= 13'd0;
      cs_n        <= 1'b1;
      frame_begin <= 1'b0;
    end else begin
      frame_begin <= 1'b0;
      case (state)
        ST_IDLE: if (enable) begin
          state   <= ST_GAP;
          gap_cnt <= 2'd0;
        end
        ST_GAP: begin
          if (gap_cnt == 2'd3) begin
            state   <= ST_CMD;
            cs_n    <= 1'b0;
            cmd_idx <= 3'd0;
          end else begin
            gap_cnt <= gap_cnt + 2'd1;
          end
        end
        ST_CMD: if (tx_done) begin
          if (cmd_idx == LAST_CMD) begin
            state       <= ST_FETCH;
            pixel_index <= 13'd0;
            fetch_cnt   <= 2'd0;
            frame_begin <= 1'b1;
          end else begin
            cmd_idx <= cmd_idx + 3'd1;
          end
        end
        ST_FETCH: begin
          if (fetch_cnt == 2'd2) begin
            pix_lo <= pixel_data[7:0];
            state  <= ST_SHIFT_HI;
          end else begin
            fetch_cnt <= fetch_cnt + 2'd1;
          end
        end
        ST_SHIFT_HI: if (tx_done) state <= ST_SHIFT_LO;
        ST_SHIFT_LO: if (tx_done) begin
          if (pixel_index != LAST_IDX) begin
            pixel_index <= pixel_index + 13'd1;
            fetch_cnt   <= 2'd0;
            state       <= ST_FETCH;
          end else begin
            // enable is only consulted here, so a frame is never cut short.
            cs_n    <= 1'b1;
            gap_cnt <= 2'd0;
            state   <= enable ? ST_GAP : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

  spi_byte_tx #(.SCLK_DIV(SCLK_DIV)) u_tx (
    .clk25    (clk25),
    .reset    (reset),
    .load     (tx_load),
    .byte_dat (tx_byte),
    .dc_in    (tx_dc),
    .sclk     (sclk),
    .mosi     (mosi),
    .dc       (dc),
    .done     (tx_done)
  );

endmodule

// File: tb/tb_oled_pixel_streamer.sv
// Bench: a reduced 4x2 raster checked byte-by-byte against a frame model, plus a full-size instance for the preamble.
module tb_oled_pixel_streamer;

  localparam int S_W       = 4;
  localparam int S_H       = 2;
  localparam int S_PIX     = S_W * S_H;
  localparam int FRAME_CYC = 4 + 6 * 32 + S_PIX * 67;
  localparam int FRAME_BYT = 6 + 2 * S_PIX;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  always #20 clk = ~clk;

  logic [15:0] s_pix, s_pix_reg;
  logic [12:0] s_idx;
  logic        s_cs_n, s_sclk, s_mosi, s_dc, s_fb, s_busy;
  logic [15:0] f_pix;
  logic [12:0] f_idx;
  logic        f_cs_n, f_sclk, f_mosi, f_dc, f_fb, f_busy;

  oled_pixel_streamer #(.WIDTH(S_W), .HEIGHT(S_H), .SCLK_DIV(4)) u_small (
    .clk25(clk), .reset(reset), .enable(enable), .pixel_data(s_pix), .pixel_index(s_idx),
    .cs_n(s_cs_n), .sclk(s_sclk), .mosi(s_mosi), .dc(s_dc), .frame_begin(s_fb), .busy(s_busy)
  );

  oled_pixel_streamer u_full (
    .clk25(clk), .reset(reset), .enable(enable), .pixel_data(f_pix), .pixel_index(f_idx),
    .cs_n(f_cs_n), .sclk(f_sclk), .mosi(f_mosi), .dc(f_dc), .frame_begin(f_fb), .busy(f_busy)
  );

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] pix_model(input int i);
    case (i)
      0: return 16'hF800;
      1: return 16'h07E0;
      2: return 16'h001F;
      3: return 16'hFFFF;
      4: return 16'h1234;
      5: return 16'hA5C3;
      6: return 16'h0001;
      default: return 16'h8000;
    endcase
  endfunction

  // {dc, byte} expected at position k of a frame's SPI byte stream.
  function automatic logic [8:0] model_byte(input int k);
    logic [15:0] px;
    case (k)
      0: return 9'h015;
      1: return 9'h000;
      2: return {1'b0, 8'(S_W - 1)};
      3: return 9'h075;
      4: return 9'h000;
      5: return {1'b0, 8'(S_H - 1)};
      default: begin
        px = pix_model((k - 6) / 2);
        return (k % 2 == 0) ? {1'b1, px[15:8]} : {1'b1, px[7:0]};
      end
    endcase
  endfunction

  // Upstream generators: one registered stage; the small one returns garbage while sclk is low.
  always @(posedge clk) s_pix_reg <= pix_model(int'(s_idx));
  assign s_pix = s_sclk ? s_pix_reg : 16'hDEAD;
  always @(posedge clk) f_pix <= (f_idx == 13'd0) ? 16'hF800 : 16'h0000;

  // Small-instance monitor: decodes SPI, compares each byte and the frame timing against the model.
  int          k, bitn, run, data_cnt, frames_done, last_fb, last_rise;
  logic [7:0]  sh;
  logic [8:0]  got;
  logic        ps, pm, ppm, pd, ppd, pcs, pbusy;
  bit          fb_valid, idle_seen;
  logic [8:0]  first_q[$];

  initial frames_done = 0;

  always @(negedge clk) begin
    if (reset) begin
      bitn = 0; k = 0; data_cnt = 0; run = 0; fb_valid = 0; idle_seen = 1;
      ps = 1; pm = 0; ppm = 0; pd = 0; ppd = 0; pcs = 1; pbusy = 0;
    end else begin
      if (s_sclk && !ps) begin
        check("mosi_stable", {ppm, pm, s_mosi}, {3{s_mosi}});
        check("dc_stable", {ppd, pd, s_dc}, {3{s_dc}});
        check("cs_at_edge", s_cs_n, 0);
        if (bitn != 0) check("sclk_period", cyc - last_rise, 4);
        last_rise = cyc;
        sh = {sh[6:0], s_mosi};
        bitn++;
        if (bitn == 8) begin
          bitn = 0;
          got = {s_dc, sh};
          check("byte", got, model_byte(k));
          if (k >= 6) begin
            check("byte_pix_idx", s_idx, (k - 6) / 2);
            data_cnt++;
          end
          if (first_q.size() < 8) first_q.push_back(got);
          k++;
          if (k == FRAME_BYT) begin
            k = 0;
            frames_done++;
          end
        end
      end
      if (s_cs_n) bitn = 0;
      if (!s_cs_n && pcs) begin
        check("gap_len", run, 4);
        data_cnt = 0;
      end
      if (s_cs_n && !pcs) begin
        check("frame_data_bytes", data_cnt, 2 * S_PIX);
        check("frame_end_pos", k, 0);
        check("last_idx", s_idx, S_PIX - 1);
      end
      run = (s_cs_n && s_busy) ? run + 1 : 0;
      if (s_fb) begin
        check("fb_pos", k, 6);
        check("fb_idx", s_idx, 0);
        if (fb_valid && !idle_seen) check("frame_period", cyc - last_fb, FRAME_CYC);
        last_fb = cyc;
        fb_valid = 1;
        idle_seen = 0;
      end
      if (!s_busy) idle_seen = 1;
      if (!s_busy && pbusy) begin
        check("idle_cs", s_cs_n, 1);
        check("idle_sclk", s_sclk, 1);
      end
      ppm = pm; pm = s_mosi; ppd = pd; pd = s_dc;
      ps = s_sclk; pcs = s_cs_n; pbusy = s_busy;
    end
  end

  // Full-size instance: capture the first ten bytes only.
  int         f_bitn;
  logic [7:0] f_sh;
  logic       f_ps;
  logic [8:0] full_q[$];

  always @(negedge clk) begin
    if (reset || f_cs_n) begin
      f_bitn = 0;
    end else if (f_sclk && !f_ps) begin
      f_sh = {f_sh[6:0], f_mosi};
      f_bitn++;
      if (f_bitn == 8) begin
        f_bitn = 0;
        if (full_q.size() < 10) full_q.push_back({f_dc, f_sh});
      end
    end
    f_ps = reset ? 1'b1 : f_sclk;
  end

  task automatic wait_cs_fall(input string name);
    int n;
    n = 0;
    while (s_cs_n && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, n, 5);
  endtask

  logic [8:0] small_exp [8] = '{9'h015, 9'h000, 9'h003, 9'h075, 9'h000, 9'h001, 9'h1F8, 9'h100};
  logic [8:0] full_exp [10] = '{9'h015, 9'h000, 9'h05F, 9'h075, 9'h000, 9'h03F,
                                9'h1F8, 9'h100, 9'h100, 9'h100};

  initial begin
    int n, base, spi_act;
    reset = 1'b1;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", s_cs_n, 1);
    check("rst_sclk", s_sclk, 1);
    check("rst_mosi", s_mosi, 0);
    check("rst_dc", s_dc, 0);
    check("rst_idx", s_idx, 0);
    check("rst_fb", s_fb, 0);
    check("rst_busy", s_busy, 0);

    enable = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    wait_cs_fall("cs_fall_cycle");

    n = 0;
    while (first_q.size() < 8 && n < 1000) begin @(posedge clk); n++; end
    check("first_bytes_seen", first_q.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < first_q.size()) check($sformatf("first_byte%0d", i), first_q[i], small_exp[i]);

    n = 0;
    while (frames_done < 3 && n < 4000) begin @(posedge clk); n++; end
    check("three_frames", frames_done, 3);

    // Drop enable mid-frame: the frame must finish, then go quiet.
    n = 0;
    while (s_idx != 13'd3 && n < 1000) begin @(posedge clk); #1; n++; end
    check("reach_pix3", s_idx, 3);
    enable = 1'b0;
    n = 0;
    while (s_busy && n < 1000) begin @(posedge clk); #1; n++; end
    check("drop_busy", s_busy, 0);
    check("drop_cs", s_cs_n, 1);
    check("drop_frames", frames_done, 4);
    spi_act = 0;
    repeat (300) begin
      @(posedge clk); #1;
      if (!s_sclk || !s_cs_n || s_busy) spi_act++;
    end
    check("quiet_after_drop", spi_act, 0);

    // Reset during the 5th bit of a pixel byte.
    enable = 1'b1;
    n = 0;
    while (!(s_idx == 13'd2 && s_dc && bitn == 4 && !s_sclk && !s_cs_n) && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    check("found_bit5", bitn, 4);
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_cs", s_cs_n, 1);
    check("mid_rst_sclk", s_sclk, 1);
    check("mid_rst_idx", s_idx, 0);
    check("mid_rst_busy", s_busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    wait_cs_fall("cs_fall_after_rst");
    base = frames_done;
    n = 0;
    while (frames_done == base && n < 1500) begin @(posedge clk); n++; end
    check("frame_after_rst", frames_done, base + 1);

    check("full_bytes_seen", full_q.size(), 10);
    for (int i = 0; i < 10; i++)
      if (i < full_q.size()) check($sformatf("full_byte%0d", i), full_q[i], full_exp[i]);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #(40 * 40000);
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end

endmodule
